fetch_ir_unit: RTL
==================

# fetch_ir_unit

Instruction fetch and instruction-register stage of the RV64I datapath. Holds the 64-bit PC, issues word requests to instruction memory, latches the returned instruction, and pre-decodes the opcode into the 4-bit immediate-format select consumed by the sign-extension stage directly downstream. A valid/ready handshake presents each instruction to the decode/extend stage, and a one-cycle redirect port (branch/jump/trap) retargets the PC.

## Interface
- RESET_PC, 64'h0, PC value loaded on reset (must be 4-byte aligned).
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_req  out  1  instruction memory request, held high until mem_ready.
- mem_addr  out  64  word address of the outstanding request; stable while mem_req=1.
- mem_ready  in  1  memory has mem_rdata valid this cycle; ends the request.
- mem_rdata  in  32  fetched instruction word.
- ir_valid  out  1  instr/imm_sel/pc_out hold a valid instruction.
- ir_ready  in  1  downstream accepts the instruction this cycle.
- instr  out  32  latched instruction word (feeds the extender input).
- imm_sel  out  4  immediate format: 0=I, 1=S, 2=B, 3=U, 4=J, 15=none/unknown.
- pc_out  out  64  address of instr.
- redir_valid  in  1  redirect request, single-cycle.
- redir_pc  in  64  redirect target.
- misalign  out  1  one-cycle pulse: redirect target had redir_pc[1:0]≠0.
- fetch_count  out  32  number of completed ir handshakes; wraps modulo 2^32.

## Operation
- States: IDLE, REQ, FLUSH, HOLD. Reset → IDLE; IDLE → REQ unconditionally next cycle.
- mem_req = 1 in REQ and FLUSH only; mem_addr = req_addr register.
- REQ: mem_addr = pc. On mem_ready: instr ← mem_rdata, imm_sel ← decode(mem_rdata[6:0]), pc_out ← pc, go HOLD.
- HOLD: ir_valid = 1. On ir_ready (no redirect): pc ← pc+4 (wraps mod 2^64), fetch_count+1, req_addr ← pc+4, go REQ.
- Redirect (any state except IDLE): pc ← {redir_pc[63:2],2'b00}; misalign pulses if redir_pc[1:0]≠0; ir_valid falls next cycle; no fetch_count increment even if ir_ready is high.
  - HOLD or REQ with mem_ready same cycle: returned data discarded; go REQ with req_addr ← new pc.
  - REQ without mem_ready: go FLUSH; req_addr keeps the old address (request never retracted). FLUSH: on mem_ready discard data, req_addr ← pc, go REQ.
  - Redirect in FLUSH: overwrites pc; stay FLUSH.
  - Redirect in IDLE: applied to pc; go REQ as normal.
- Opcode decode: 0000011, 0010011, 0011011, 1100111, 1110011 → 0; 0100011 → 1; 1100011 → 2; 0110111, 0010111 → 3; 1101111 → 4; all others (incl. R-type 0110011/0111011) → 15.

## Timing
- Reset values: mem_req=0, mem_addr=RESET_PC, ir_valid=0, instr=0, imm_sel=15, pc_out=0, misalign=0, fetch_count=0; pc=RESET_PC; state IDLE.
- Reset mid-request: request dropped immediately (async); memory side tolerates this only under reset.
- First mem_req: cycle after reset deasserts +1 (IDLE cycle).
- Latency: mem_ready in cycle N → ir_valid=1 in N+1; with zero-wait memory and ir_ready held high, one instruction every 2 cycles.
- ir_valid, instr, imm_sel, pc_out are registered and stable while ir_valid=1 and ir_ready=0.
- misalign registered; high exactly the cycle after the redirect.
- Redirect and ir_ready in same cycle: redirect wins.

## Test plan
- Reset RESET_PC=0x1000, mem_ready tied high, memory returns 0x00500093 then 0x00112023, ir_ready=1 → mem_addr 0x1000, 0x1004; imm_sel 0 then 1; ir_valid every other cycle; fetch_count=2.
- mem_ready delayed 3 cycles → mem_req and mem_addr stable for all 4 cycles; ir_valid one cycle after mem_ready.
- ir_ready=0 for 5 cycles in HOLD with instr 0xFE000EE3 → instr, imm_sel=2, pc_out held; no new mem_req; pc advances only after ir_ready.
- Redirect to 0x2002 in HOLD with ir_ready=1 → misalign pulse, next mem_addr 0x2000, fetch_count unchanged.
- Redirect to 0x3000 while request to 0x1004 outstanding, mem_ready 2 cycles later → FLUSH keeps mem_addr 0x1004, data discarded, ir_valid stays 0, then request 0x3000.
- RESET_PC=0xFFFF_FFFF_FFFF_FFFC, one handshake → next mem_addr 0x0; opcodes 0x37, 0x6F, 0x33 → imm_sel 3, 4, 15.

Source files
------------

// File: rtl/fetch_ir_unit.sv
// fetch_ir_unit: RV64I fetch and instruction-register stage. It issues word fetches,
// latches the returned instruction with its immediate-format pre-decode, and applies redirects.
module fetch_ir_unit #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic [31:0] instr,
  output logic [3:0]  imm_sel,
  output logic [63:0] pc_out,
  input  logic        redir_valid,
  input  logic [63:0] redir_pc,
  output logic        misalign,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    FLUSH = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam logic [3:0] SEL_I    = 4'd0;
  localparam logic [3:0] SEL_S    = 4'd1;
  localparam logic [3:0] SEL_B    = 4'd2;
  localparam logic [3:0] SEL_U    = 4'd3;
  localparam logic [3:0] SEL_J    = 4'd4;
  localparam logic [3:0] SEL_NONE = 4'd15;

  function automatic logic [3:0] imm_decode(input logic [6:0] opcode);
    logic [3:0] sel;
    case (opcode)
      7'b0000011, 7'b0010011, 7'b0011011,
      7'b1100111, 7'b1110011:             sel = SEL_I;
      7'b0100011:                         sel = SEL_S;
      7'b1100011:                         sel = SEL_B;
      7'b0110111, 7'b0010111:             sel = SEL_U;
      7'b1101111:                         sel = SEL_J;
      default:                            sel = SEL_NONE;
    endcase
    return sel;
  endfunction

  state_t      state_r, state_s;
  logic [63:0] pc_r, pc_s;
  logic [63:0] req_addr_r, req_addr_s;
  logic        mem_req_r, mem_req_s;
  logic        ir_valid_r, ir_valid_s;
  logic        misalign_r, misalign_s;
  logic [31:0] instr_r;
  logic [3:0]  imm_sel_r;
  logic [63:0] pc_out_r;
  logic [31:0] fetch_count_r;
  logic        capture_s;
  logic        handshake_s;
  logic [63:0] redir_tgt_s;
  logic [63:0] pc_inc_s;

  assign redir_tgt_s = {redir_pc[63:2], 2'b00};
  assign pc_inc_s    = pc_r + 64'd4;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; a redirect always beats the downstream handshake.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: state_s = REQ;
      REQ: begin
        if (redir_valid) begin
          // An unanswered request cannot be retracted, so it is drained in FLUSH.
          state_s = mem_ready ? REQ : FLUSH;
        end else if (mem_ready) begin
          state_s = HOLD;
        end else begin
          state_s = REQ;
        end
      end
      FLUSH: begin
        if (mem_ready) begin
          state_s = REQ;
        end else begin
          state_s = FLUSH;
        end
      end
      HOLD: begin
        if (redir_valid || ir_ready) begin
          state_s = REQ;
        end else begin
          state_s = HOLD;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Output and datapath control: next pc, next request address, IR capture, handshake.
  always_comb begin
    pc_s        = pc_r;
    req_addr_s  = req_addr_r;
    capture_s   = 1'b0;
    handshake_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (redir_valid) begin
          pc_s = redir_tgt_s;
        end else begin
          pc_s = pc_r;
        end
        req_addr_s = pc_s;
      end
      REQ: begin
        if (redir_valid) begin
          pc_s = redir_tgt_s;
          if (mem_ready) begin
            req_addr_s = redir_tgt_s;
          end else begin
            req_addr_s = req_addr_r;
          end
        end else if (mem_ready) begin
          capture_s = 1'b1;
        end else begin
          capture_s = 1'b0;
        end
      end
      FLUSH: begin
        if (redir_valid) begin
          pc_s = redir_tgt_s;
        end else begin
          pc_s = pc_r;
        end
        if (mem_ready) begin
          req_addr_s = pc_s;
        end else begin
          req_addr_s = req_addr_r;
        end
      end
      HOLD: begin
        if (redir_valid) begin
          pc_s       = redir_tgt_s;
          req_addr_s = redir_tgt_s;
        end else if (ir_ready) begin
          pc_s        = pc_inc_s;
          req_addr_s  = pc_inc_s;
          handshake_s = 1'b1;
        end else begin
          pc_s = pc_r;
        end
      end
      default: begin
        pc_s       = pc_r;
        req_addr_s = req_addr_r;
      end
    endcase
    mem_req_s  = (state_s == REQ) || (state_s == FLUSH);
    ir_valid_s = (state_s == HOLD);
    misalign_s = redir_valid && (redir_pc[1:0] != 2'b00);
  end

  // Registered handshake and status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req_r  <= 1'b0;
      ir_valid_r <= 1'b0;
      misalign_r <= 1'b0;
    end else begin
      mem_req_r  <= mem_req_s;
      ir_valid_r <= ir_valid_s;
      misalign_r <= misalign_s;
    end
  end

  // Program counter and outstanding request address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_r       <= RESET_PC;
      req_addr_r <= RESET_PC;
    end else begin
      pc_r       <= pc_s;
      req_addr_r <= req_addr_s;
    end
  end

  // Instruction register with opcode pre-decode, plus completed-handshake counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_r       <= 32'd0;
      imm_sel_r     <= SEL_NONE;
      pc_out_r      <= 64'd0;
      fetch_count_r <= 32'd0;
    end else begin
      if (capture_s) begin
        instr_r   <= mem_rdata;
        imm_sel_r <= imm_decode(mem_rdata[6:0]);
        pc_out_r  <= pc_r;
      end
      if (handshake_s) begin
        fetch_count_r <= fetch_count_r + 32'd1;
      end
    end
  end

  assign mem_req     = mem_req_r;
  assign mem_addr    = req_addr_r;
  assign ir_valid    = ir_valid_r;
  assign instr       = instr_r;
  assign imm_sel     = imm_sel_r;
  assign pc_out      = pc_out_r;
  assign misalign    = misalign_r;
  assign fetch_count = fetch_count_r;

endmodule
